// File: rtl/lsu_mem_stage.sv
// Load/store unit between EXU and the memory black box: one request in flight, one response out.
// Latency req->resp_valid: store 2 cycles, load MEM_LAT+1 cycles (1 cycle for a trapped misaligned access).
// Backpressure: req_ready is high only in IDLE; the response is held stable in RESP until resp_ready.
// Optional feature: define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of aligning them down.
module lsu_mem_stage #(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic [63:0] mem_raddr,
  output logic        mem_read,
  output logic [63:0] mem_waddr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  output logic        mem_write,
  input  logic [63:0] mem_rdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_data,
  output logic [4:0]  resp_rd,
  output logic        resp_err
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  // Counter wide enough to hold 0..MEM_LAT-1.
  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LAT - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wen_q, wen_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;
  logic [63:0]   addr_q, addr_d;
  logic [63:0]   wdata_q, wdata_d;
  logic [4:0]    rd_q, rd_d;
  logic [63:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          mem_read_q, mem_read_d;
  logic          mem_write_q, mem_write_d;
  logic          resp_valid_q, resp_valid_d;
  logic          req_ready_q, req_ready_d;
  logic          trap_hit;

  // Address bits that must be zero for a naturally aligned access of this size.
  function automatic logic [2:0] low_mask(input logic [1:0] size);
    case (size)
      2'd0:    low_mask = 3'b000;
      2'd1:    low_mask = 3'b001;
      2'd2:    low_mask = 3'b011;
      default: low_mask = 3'b111;
    endcase
  endfunction

  // Byte-enable pattern of an access, before shifting to its lane.
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    case (size)
      2'd0:    size_mask = 8'h01;
      2'd1:    size_mask = 8'h03;
      2'd2:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  endfunction

  // Pull the addressed bytes out of the doubleword and extend them to 64 bits.
  function automatic logic [63:0] extract(input logic [63:0] raw, input logic [2:0] off,
                                          input logic [1:0] size, input logic uns);
    logic [63:0] sh;
    sh = raw >> {off, 3'b000};
    case (size)
      2'd0:    extract = uns ? {56'b0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
      2'd1:    extract = uns ? {48'b0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
      2'd2:    extract = uns ? {32'b0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
      default: extract = sh;
    endcase
  endfunction

  // Misaligned requests skip the memory access only when trapping is built in.
`ifdef LSU_MISALIGN_TRAP_EN
  assign trap_hit = |(req_addr[2:0] & low_mask(req_size));
`else
  assign trap_hit = 1'b0;
`endif

  // Next-state and next-output computation for the IDLE/ACCESS/RESP sequence.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wen_d        = wen_q;
    size_d       = size_q;
    uns_d        = uns_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rd_d         = rd_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    resp_valid_d = resp_valid_q;
    req_ready_d  = req_ready_q;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          wen_d       = req_wen;
          size_d      = req_size;
          uns_d       = req_unsigned;
          // Aligning down is a no-op for aligned requests, and trapped ones never touch memory.
          addr_d      = req_addr & ~{61'b0, low_mask(req_size)};
          wdata_d     = req_wdata;
          rd_d        = req_rd;
          rdata_d     = 64'b0;
          cnt_d       = '0;
          req_ready_d = 1'b0;
          if (trap_hit) begin
            err_d        = 1'b1;
            resp_valid_d = 1'b1;
            state_d      = RESP;
          end else begin
            err_d       = 1'b0;
            mem_write_d = req_wen;
            mem_read_d  = ~req_wen;
            state_d     = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (wen_q) begin
          mem_write_d  = 1'b0;
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end else if (cnt_q == CNT_LAST) begin
          mem_read_d   = 1'b0;
          rdata_d      = extract(mem_rdata, addr_q[2:0], size_q, uns_q);
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
          state_d      = IDLE;
        end
      end
      default: begin
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        resp_valid_d = 1'b0;
        req_ready_d  = 1'b1;
        state_d      = IDLE;
      end
    endcase
  end

  // State, latched request fields and registered outputs; reset drops everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      wen_q        <= 1'b0;
      size_q       <= 2'b0;
      uns_q        <= 1'b0;
      addr_q       <= 64'b0;
      wdata_q      <= 64'b0;
      rd_q         <= 5'b0;
      rdata_q      <= 64'b0;
      err_q        <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      req_ready_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wen_q        <= wen_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rd_q         <= rd_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      resp_valid_q <= resp_valid_d;
      req_ready_q  <= req_ready_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign mem_raddr  = {addr_q[63:3], 3'b000};
  assign mem_waddr  = {addr_q[63:3], 3'b000};
  // Lane data and byte enables only show while the write strobe is up.
  assign mem_wdata  = mem_write_q ? (wdata_q << {addr_q[2:0], 3'b000}) : 64'b0;
  assign mem_wmask  = mem_write_q ? (size_mask(size_q) << addr_q[2:0]) : 8'b0;
  assign resp_valid = resp_valid_q;
  assign resp_data  = rdata_q;
  assign resp_rd    = rd_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
module tb_lsu_mem_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, sel, req_valid, req_wen, req_unsigned, resp_ready;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_wdata, mem_rdata;
  logic [4:0]  req_rd;

  logic        r0_req_ready, r0_mem_read, r0_mem_write, r0_resp_valid, r0_resp_err;
  logic [63:0] r0_mem_raddr, r0_mem_waddr, r0_mem_wdata, r0_resp_data;
  logic [7:0]  r0_mem_wmask;
  logic [4:0]  r0_resp_rd;
  logic        r1_req_ready, r1_mem_read, r1_mem_write, r1_resp_valid, r1_resp_err;
  logic [63:0] r1_mem_raddr, r1_mem_waddr, r1_mem_wdata, r1_resp_data;
  logic [7:0]  r1_mem_wmask;
  logic [4:0]  r1_resp_rd;

  lsu_mem_stage #(.MEM_LAT(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid && !sel), .req_ready(r0_req_ready),
    .req_wen(req_wen), .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd), .mem_raddr(r0_mem_raddr), .mem_read(r0_mem_read),
    .mem_waddr(r0_mem_waddr), .mem_wdata(r0_mem_wdata), .mem_wmask(r0_mem_wmask),
    .mem_write(r0_mem_write), .mem_rdata(mem_rdata), .resp_valid(r0_resp_valid),
    .resp_ready(resp_ready), .resp_data(r0_resp_data), .resp_rd(r0_resp_rd), .resp_err(r0_resp_err));

  lsu_mem_stage #(.MEM_LAT(3)) u_lat3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid && sel), .req_ready(r1_req_ready),
    .req_wen(req_wen), .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd), .mem_raddr(r1_mem_raddr), .mem_read(r1_mem_read),
    .mem_waddr(r1_mem_waddr), .mem_wdata(r1_mem_wdata), .mem_wmask(r1_mem_wmask),
    .mem_write(r1_mem_write), .mem_rdata(mem_rdata), .resp_valid(r1_resp_valid),
    .resp_ready(resp_ready), .resp_data(r1_resp_data), .resp_rd(r1_resp_rd), .resp_err(r1_resp_err));

  // Observed view: whichever instance is currently selected.
  wire        m_req_ready  = sel ? r1_req_ready  : r0_req_ready;
  wire        m_mem_read   = sel ? r1_mem_read   : r0_mem_read;
  wire        m_mem_write  = sel ? r1_mem_write  : r0_mem_write;
  wire [63:0] m_mem_raddr  = sel ? r1_mem_raddr  : r0_mem_raddr;
  wire [63:0] m_mem_waddr  = sel ? r1_mem_waddr  : r0_mem_waddr;
  wire [63:0] m_mem_wdata  = sel ? r1_mem_wdata  : r0_mem_wdata;
  wire [7:0]  m_mem_wmask  = sel ? r1_mem_wmask  : r0_mem_wmask;
  wire        m_resp_valid = sel ? r1_resp_valid : r0_resp_valid;
  wire [63:0] m_resp_data  = sel ? r1_resp_data  : r0_resp_data;
  wire [4:0]  m_resp_rd    = sel ? r1_resp_rd    : r0_resp_rd;
  wire        m_resp_err   = sel ? r1_resp_err   : r0_resp_err;

  typedef struct packed {
    logic [63:0] data;
    logic [4:0]  rd;
    logic        err;
  } resp_t;

  typedef struct packed {
    logic        wr;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic [7:0]  nread;
  } memop_t;

  resp_t  resp_q[$];
  memop_t mem_q[$];
  int     checks = 0;
  int     failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Response monitor: every accepted response is popped and compared against the scoreboard.
  always @(negedge clk) begin
    resp_t e;
    if (rst_n && m_resp_valid) begin
      chk("strobe_during_resp", {62'b0, m_mem_read, m_mem_write}, 64'd0);
      if (resp_ready) begin
        if (resp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_resp act=rd%0d exp=none", m_resp_rd);
        end else begin
          e = resp_q.pop_front();
          chk("resp_data", m_resp_data, e.data);
          chk("resp_rd", {59'b0, m_resp_rd}, {59'b0, e.rd});
          chk("resp_err", {63'b0, m_resp_err}, {63'b0, e.err});
        end
      end
    end
  end

  // Memory-port monitor: writes are checked per strobe cycle, reads once their strobe run ends.
  int          rd_run = 0;
  logic [63:0] rd_addr_cap = 64'b0;
  always @(negedge clk) begin
    memop_t e;
    if (!rst_n) begin
      rd_run = 0;
    end else begin
      if (m_mem_read && m_mem_write) begin
        checks++; failures++;
        $display("FAIL both_strobes act=11 exp=not_both");
      end
      if (m_mem_write) begin
        if (mem_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_write act=%h exp=none", m_mem_waddr);
        end else begin
          e = mem_q.pop_front();
          chk("op_is_write", 64'd1, {63'b0, e.wr});
          chk("mem_waddr", m_mem_waddr, e.addr);
          chk("mem_wdata", m_mem_wdata, e.wdata);
          chk("mem_wmask", {56'b0, m_mem_wmask}, {56'b0, e.wmask});
        end
      end
      if (m_mem_read) begin
        if (rd_run == 0) rd_addr_cap = m_mem_raddr;
        rd_run++;
      end else if (rd_run > 0) begin
        if (mem_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_read act=%h exp=none", rd_addr_cap);
        end else begin
          e = mem_q.pop_front();
          chk("op_is_read", 64'd0, {63'b0, e.wr});
          chk("mem_raddr", rd_addr_cap, e.addr);
          chk("mem_read_cycles", 64'(rd_run), {56'b0, e.nread});
        end
        rd_run = 0;
      end
    end
  end

  // One request through the selected DUT; entered and left at 1 time unit after a rising edge.
  task automatic do_req(input logic wen, input logic [1:0] size, input logic uns,
                        input logic [63:0] addr, input logic [63:0] wdata, input logic [4:0] rd,
                        input logic [63:0] rdata_early, input logic [63:0] rdata_final, input int sw_at,
                        input logic mem_exp, input logic [63:0] m_addr, input logic [63:0] m_wdata,
                        input logic [7:0] m_wmask, input logic [7:0] m_nread,
                        input logic [63:0] e_data, input logic e_err, input int e_lat, input int hold);
    int  lat, k;
    bit  ok;
    if (mem_exp) mem_q.push_back('{wr: wen, addr: m_addr, wdata: m_wdata, wmask: m_wmask, nread: m_nread});
    resp_q.push_back('{data: e_data, rd: rd, err: e_err});
    mem_rdata = rdata_early;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (m_req_ready) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (!ok) chk("req_ready_timeout", 64'd0, 64'd1);
    req_wen = wen; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; req_rd = rd; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_wdata = 64'hDEAD_DEAD_DEAD_DEAD;
    lat = 1; k = 0;
    while (!m_resp_valid && lat < 30) begin
      if (k == sw_at) mem_rdata = rdata_final;
      @(posedge clk); #1;
      lat++; k++;
    end
    chk("latency", 64'(lat), 64'(e_lat));
    if (hold > 0) begin
      resp_ready = 1'b0;
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        chk("hold_resp_valid", {63'b0, m_resp_valid}, 64'd1);
        chk("hold_resp_data", m_resp_data, e_data);
        chk("hold_req_ready", {63'b0, m_req_ready}, 64'd0);
      end
      resp_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("req_ready_after_hs", {63'b0, m_req_ready}, 64'd1);
    chk("resp_valid_after_hs", {63'b0, m_resp_valid}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; sel = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = 64'b0; req_wdata = 64'b0; req_rd = 5'd0;
    resp_ready = 1'b1; mem_rdata = 64'b0;
    #12;
    chk("rst_req_ready",  {63'b0, m_req_ready},  64'd1);
    chk("rst_resp_valid", {63'b0, m_resp_valid}, 64'd0);
    chk("rst_strobes",    {62'b0, m_mem_read, m_mem_write}, 64'd0);
    chk("rst_raddr",      m_mem_raddr, 64'd0);
    chk("rst_wmask",      {56'b0, m_mem_wmask}, 64'd0);
    chk("rst_resp_data",  m_resp_data, 64'd0);
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // MEM_LAT=1 instance: loads, stores, extension, lane placement, backpressure.
    do_req(0, 2'd3, 0, 64'h8000_0010, 0, 5'd5, 64'h1122334455667788, 64'h1122334455667788, 0,
           1, 64'h8000_0010, 0, 0, 8'd1, 64'h1122334455667788, 0, 2, 0);
    do_req(0, 2'd0, 0, 64'h8000_0005, 0, 5'd7, 64'h0000800000000000, 64'h0000800000000000, 0,
           1, 64'h8000_0000, 0, 0, 8'd1, 64'hFFFF_FFFF_FFFF_FF80, 0, 2, 0);
    do_req(0, 2'd0, 1, 64'h8000_0005, 0, 5'd8, 64'h0000800000000000, 64'h0000800000000000, 0,
           1, 64'h8000_0000, 0, 0, 8'd1, 64'h80, 0, 2, 0);
    do_req(1, 2'd1, 0, 64'h8000_0006, 64'hABCD, 5'd9, 0, 0, 0,
           1, 64'h8000_0000, 64'hABCD_0000_0000_0000, 8'hC0, 8'd0, 64'd0, 0, 2, 0);
    do_req(0, 2'd1, 1, 64'h8000_0002, 0, 5'd10, 64'h00000000F00D0000, 64'h00000000F00D0000, 0,
           1, 64'h8000_0000, 0, 0, 8'd1, 64'hF00D, 0, 2, 0);
    do_req(0, 2'd2, 0, 64'h8000_0004, 0, 5'd11, 64'h89ABCDEF00000000, 64'h89ABCDEF00000000, 0,
           1, 64'h8000_0000, 0, 0, 8'd1, 64'hFFFF_FFFF_89AB_CDEF, 0, 2, 0);
    do_req(1, 2'd3, 0, 64'h8000_0018, 64'h0123456789ABCDEF, 5'd12, 0, 0, 0,
           1, 64'h8000_0018, 64'h0123456789ABCDEF, 8'hFF, 8'd0, 64'd0, 0, 2, 0);
    do_req(1, 2'd0, 0, 64'h8000_0023, 64'hFF5A, 5'd13, 0, 0, 0,
           1, 64'h8000_0020, 64'h0000_00FF_5A00_0000, 8'h08, 8'd0, 64'd0, 0, 2, 0);
    do_req(0, 2'd3, 0, 64'h8000_0008, 0, 5'd14, 64'hCAFEF00DDEADBEEF, 64'hCAFEF00DDEADBEEF, 0,
           1, 64'h8000_0008, 0, 0, 8'd1, 64'hCAFEF00DDEADBEEF, 0, 2, 5);
`ifdef LSU_MISALIGN_TRAP_EN
    do_req(0, 2'd2, 0, 64'h8000_0002, 0, 5'd15, 64'h00000000DEADBEEF, 64'h00000000DEADBEEF, 0,
           0, 0, 0, 0, 8'd0, 64'd0, 1, 1, 0);
    do_req(1, 2'd3, 0, 64'h8000_0013, 64'h55AA, 5'd16, 0, 0, 0,
           0, 0, 0, 0, 8'd0, 64'd0, 1, 1, 0);
`else
    do_req(0, 2'd2, 0, 64'h8000_0002, 0, 5'd15, 64'h00000000DEADBEEF, 64'h00000000DEADBEEF, 0,
           1, 64'h8000_0000, 0, 0, 8'd1, 64'hFFFF_FFFF_DEAD_BEEF, 0, 2, 0);
    do_req(1, 2'd3, 0, 64'h8000_0013, 64'h55AA, 5'd16, 0, 0, 0,
           1, 64'h8000_0010, 64'h55AA, 8'hFF, 8'd0, 64'd0, 0, 2, 0);
`endif

    // MEM_LAT=3 instance: reset pulse in the middle of a load, then recovery.
    sel = 1'b1;
    req_wen = 1'b0; req_size = 2'd2; req_unsigned = 1'b1; req_addr = 64'h8000_0004;
    req_rd = 5'd20; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst_pre_read", {63'b0, m_mem_read}, 64'd1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_strobes", {62'b0, m_mem_read, m_mem_write}, 64'd0);
    chk("rst_mid_resp_valid", {63'b0, m_resp_valid}, 64'd0);
    chk("rst_mid_req_ready", {63'b0, m_req_ready}, 64'd1);
    @(posedge clk); #3 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("post_rst_no_resp", {63'b0, m_resp_valid}, 64'd0);
    end
    chk("post_rst_req_ready", {63'b0, m_req_ready}, 64'd1);

    do_req(0, 2'd2, 1, 64'h8000_0004, 0, 5'd17, 64'hFFFF_FFFF_FFFF_FFFF, 64'h12345678_9ABCDEF0, 2,
           1, 64'h8000_0000, 0, 0, 8'd3, 64'h1234_5678, 0, 4, 0);
    do_req(1, 2'd0, 0, 64'h8000_0001, 64'h7E, 5'd18, 0, 0, 0,
           1, 64'h8000_0000, 64'h7E00, 8'h02, 8'd0, 64'd0, 0, 2, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("resp_queue_empty", 64'(resp_q.size()), 64'd0);
    chk("mem_queue_empty", 64'(mem_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
